// File: rtl/ssc_pkg.sv
// rtl/ssc_pkg.sv - shared types, mux encodings and output decode for the sort controller
package ssc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_CAP_I,
        S_RD_J,
        S_CMP_J,
        S_WR_I_SET,
        S_WR_I,
        S_WR_M_SET,
        S_WR_M,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [1:0] AMUX_CNT1 = 2'b00;
    localparam logic [1:0] AMUX_CNT2 = 2'b01;
    localparam logic [1:0] AMUX_MIN  = 2'b10;
    localparam logic       DMUX_MIN  = 1'b0;
    localparam logic       DMUX_TEMP = 1'b1;

    typedef struct packed {
        logic       load_temp;
        logic       sel_mux;
        logic [1:0] sel_amux;
        logic       sel_dmux;
        logic       load_min;
        logic       mem_we;
        logic       busy;
        logic       done;
    } ctrl_t;

    // Moore output pattern for a state; registered on entry to that state.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_RD_I: begin
                c.sel_amux = AMUX_CNT1;
            end
            S_CAP_I: begin
                c.sel_amux  = AMUX_CNT1;
                c.load_min  = 1'b1;
                c.load_temp = 1'b1;
            end
            S_RD_J, S_CMP_J: begin
                c.sel_amux = AMUX_CNT2;
                c.sel_mux  = 1'b1;
            end
            S_WR_I_SET: begin
                c.sel_amux = AMUX_CNT1;
                c.sel_dmux = DMUX_MIN;
            end
            S_WR_I: begin
                c.sel_amux = AMUX_CNT1;
                c.sel_dmux = DMUX_MIN;
                c.mem_we   = 1'b1;
            end
            S_WR_M_SET: begin
                c.sel_amux = AMUX_MIN;
                c.sel_dmux = DMUX_TEMP;
            end
            S_WR_M: begin
                c.sel_amux = AMUX_MIN;
                c.sel_dmux = DMUX_TEMP;
                c.mem_we   = 1'b1;
            end
            S_DONE: begin
                c.done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ssc_if.sv
// rtl/ssc_if.sv - controller-to-datapath strobe and status bundle
// The controller drives everything except start.
interface ssc_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] cnt1_out;
    logic [ADDR_W-1:0] cnt2_out;
    logic              load_temp;
    logic              sel_mux;
    logic [1:0]        Sel_AMux;
    logic              Sel_DMux;
    logic              Load_min;
    logic              mem_we;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        output cnt1_out, cnt2_out, load_temp, sel_mux, Sel_AMux,
               Sel_DMux, Load_min, mem_we, busy, done
    );

    modport slave (
        output start,
        input  cnt1_out, cnt2_out, load_temp, sel_mux, Sel_AMux,
               Sel_DMux, Load_min, mem_we, busy, done
    );
endinterface

// File: rtl/ssc_counter.sv
// rtl/ssc_counter.sv - loadable up-counter used for the outer and inner sort indices
// Load wins over increment; reset clears asynchronously.
module ssc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ssc_controller.sv
// rtl/ssc_controller.sv - selection-sort sequencing FSM for the sort datapath
// Each memory access is a select cycle followed by an act cycle, since the datapath registers address/data.
module ssc_controller
    import ssc_pkg::*;
#(
    parameter int N      = 16,
    parameter int ADDR_W = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    ssc_if.master  bus
);

    if (N < 2 || N > 256 || (N - 1) >= (2 ** ADDR_W)) begin : g_bad_param
        $error("ssc_controller: N must be 2..256 and fit in ADDR_W bits");
    end

    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(N - 2);

    state_t            state;
    ctrl_t             ctrl;
    logic [ADDR_W-1:0] cnt1;
    logic [ADDR_W-1:0] cnt2;
    logic              cnt1_load;
    logic              cnt1_inc;
    logic              cnt2_load;
    logic              cnt2_inc;

    // Counter updates take effect on the edge that leaves the current state.
    always_comb begin
        cnt1_load = 1'b0;
        cnt1_inc  = 1'b0;
        cnt2_load = 1'b0;
        cnt2_inc  = 1'b0;
        case (state)
            S_IDLE:  cnt1_load = bus.start;
            S_CAP_I: cnt2_load = 1'b1;
            S_CMP_J: cnt2_inc  = (cnt2 != LAST_J);
            S_NEXT:  cnt1_inc  = (cnt1 != LAST_I);
            default: ;
        endcase
    end

    ssc_counter #(.ADDR_W(ADDR_W)) u_cnt1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt1_load),
        .load_value ('0),
        .inc        (cnt1_inc),
        .count      (cnt1)
    );

    ssc_counter #(.ADDR_W(ADDR_W)) u_cnt2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt2_load),
        .load_value (cnt1 + ADDR_W'(1)),
        .inc        (cnt2_inc),
        .count      (cnt2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ctrl  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_RD_I;
                        ctrl  <= decode(S_RD_I);
                    end
                end
                S_RD_I: begin
                    state <= S_CAP_I;
                    ctrl  <= decode(S_CAP_I);
                end
                S_CAP_I: begin
                    state <= S_RD_J;
                    ctrl  <= decode(S_RD_J);
                end
                S_RD_J: begin
                    state <= S_CMP_J;
                    ctrl  <= decode(S_CMP_J);
                end
                S_CMP_J: begin
                    if (cnt2 == LAST_J) begin
                        state <= S_WR_I_SET;
                        ctrl  <= decode(S_WR_I_SET);
                    end else begin
                        state <= S_RD_J;
                        ctrl  <= decode(S_RD_J);
                    end
                end
                S_WR_I_SET: begin
                    state <= S_WR_I;
                    ctrl  <= decode(S_WR_I);
                end
                S_WR_I: begin
                    state <= S_WR_M_SET;
                    ctrl  <= decode(S_WR_M_SET);
                end
                S_WR_M_SET: begin
                    state <= S_WR_M;
                    ctrl  <= decode(S_WR_M);
                end
                S_WR_M: begin
                    state <= S_NEXT;
                    ctrl  <= decode(S_NEXT);
                end
                S_NEXT: begin
                    if (cnt1 == LAST_I) begin
                        state <= S_DONE;
                        ctrl  <= decode(S_DONE);
                    end else begin
                        state <= S_RD_I;
                        ctrl  <= decode(S_RD_I);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ctrl  <= decode(S_IDLE);
                end
                default: begin
                    state <= S_IDLE;
                    ctrl  <= '0;
                end
            endcase
        end
    end

    assign bus.cnt1_out  = cnt1;
    assign bus.cnt2_out  = cnt2;
    assign bus.load_temp = ctrl.load_temp;
    assign bus.sel_mux   = ctrl.sel_mux;
    assign bus.Sel_AMux  = ctrl.sel_amux;
    assign bus.Sel_DMux  = ctrl.sel_dmux;
    assign bus.Load_min  = ctrl.load_min;
    assign bus.mem_we    = ctrl.mem_we;
    assign bus.busy      = ctrl.busy;
    assign bus.done      = ctrl.done;

endmodule

// File: tb/tb_ssc_controller.sv
// tb/tb_ssc_controller.sv - bench for ssc_controller with a behavioural sort datapath and memory
// Expected writes and completion records come from a reference selection sort.
module tb_ssc_controller;

    localparam int N      = 4;
    localparam int ADDR_W = 8;
    localparam int AW     = $clog2(N);
    localparam int DONE_AT = 7 * (N - 1) + N * (N - 1) + 1;

    typedef struct packed {
        logic [N-1:0][15:0] data;
        logic [N-1:0][15:0] sorted;
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct packed {
        int unsigned        cycle;
        logic [N-1:0][15:0] mem;
    } exp_done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssc_if #(.ADDR_W(ADDR_W)) bus ();

    ssc_controller #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0]        mem [N];
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  min_addr;
    logic [15:0]        wdata_q;
    logic [15:0]        temp_q;
    logic [15:0]        min_q;
    logic [15:0]        rd;
    logic               preload_en = 1'b0;
    logic [N-1:0][15:0] preload_val;

    assign rd = mem[addr_q[AW-1:0]];

    always @(posedge clk) begin
        if (preload_en) begin
            for (int k = 0; k < N; k++) mem[k] <= preload_val[k];
        end else if (bus.mem_we) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
        case (bus.Sel_AMux)
            2'b00:   addr_q <= bus.cnt1_out;
            2'b01:   addr_q <= bus.cnt2_out;
            default: addr_q <= min_addr;
        endcase
        wdata_q <= bus.Sel_DMux ? temp_q : min_q;
        if (bus.load_temp) temp_q <= rd;
        if (bus.Load_min || (bus.sel_mux && bus.Sel_AMux == 2'b01 && rd < min_q)) begin
            min_q    <= rd;
            min_addr <= bus.sel_mux ? bus.cnt2_out : bus.cnt1_out;
        end
    end

    int        checks = 0;
    int        failures = 0;
    int        cyc;
    int        done_cnt;
    logic      prev_we;
    wr_t       wr_q[$];
    exp_done_t done_q[$];
    vec_t      vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, s0, s1, s2, s3);
        vec_t v;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.sorted[0] = s0; v.sorted[1] = s1; v.sorted[2] = s2; v.sorted[3] = s3;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.cnt1_out, bus.cnt2_out, bus.load_temp, bus.sel_mux, bus.Sel_AMux,
                    bus.Sel_DMux, bus.Load_min, bus.mem_we, bus.busy, bus.done});
    endfunction

    function automatic logic [N-1:0][15:0] snap();
        logic [N-1:0][15:0] s;
        for (int k = 0; k < N; k++) s[k] = mem[k];
        return s;
    endfunction

    task automatic expect_sort(input logic [N-1:0][15:0] init, input int unsigned at);
        logic [N-1:0][15:0] a;
        logic [15:0]        t;
        int                 m;
        wr_t                w;
        exp_done_t          d;
        a = init;
        for (int i = 0; i < N - 1; i++) begin
            m = i;
            for (int j = i + 1; j < N; j++) if (a[j] < a[m]) m = j;
            w.addr = ADDR_W'(i); w.data = a[m]; wr_q.push_back(w);
            w.addr = ADDR_W'(m); w.data = a[i]; wr_q.push_back(w);
            t = a[i]; a[i] = a[m]; a[m] = t;
        end
        d.cycle = at;
        d.mem   = a;
        done_q.push_back(d);
    endtask

    task automatic tick();
        wr_t       w;
        exp_done_t d;
        @(negedge clk);
        cyc++;
        if (bus.mem_we) begin
            check("we_back_to_back", 64'(prev_we), 64'(0));
            check("we_in_read_state", 64'({bus.load_temp, bus.sel_mux, bus.Load_min}), 64'(0));
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write cycle=%0d actual_addr=%0d required=none", cyc, addr_q);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 64'(addr_q), 64'(w.addr));
                check("wr_data", 64'(wdata_q), 64'(w.data));
            end
        end
        prev_we = bus.mem_we;
        if (bus.done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cycle=%0d actual=1 required=0", cyc);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(d.cycle));
                for (int k = 0; k < N; k++) check("done_mem", 64'(mem[k]), 64'(d.mem[k]));
            end
        end
    endtask

    task automatic load_mem(input logic [N-1:0][15:0] d);
        @(negedge clk);
        preload_val = d;
        preload_en  = 1'b1;
        @(negedge clk);
        preload_en  = 1'b0;
    endtask

    task automatic begin_sort();
        bus.start = 1'b1;
        expect_sort(snap(), DONE_AT);
        cyc      = 0;
        done_cnt = 0;
        prev_we  = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        cyc = 0;
        done_cnt = 0;
        prev_we = 1'b0;
        vecs[0] = mk(16'd3, 16'd1, 16'd2, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3);
        vecs[1] = mk(16'd5, 16'd6, 16'd7, 16'd8, 16'd5, 16'd6, 16'd7, 16'd8);
        vecs[2] = mk(16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2);
        vecs[3] = mk(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF);

        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 64'(0));
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", outs(), 64'(0));

        for (int v = 0; v < 4; v++) begin
            load_mem(vecs[v].data);
            begin_sort();
            for (int c = 1; c <= DONE_AT + 2; c++) begin
                tick();
                if (c == 1) bus.start = 1'b0;
                check("busy", 64'(bus.busy), 64'(c <= DONE_AT));
            end
            check("done_count", 64'(done_cnt), 64'(1));
            check("queues_drained", 64'(wr_q.size() + done_q.size()), 64'(0));
            for (int k = 0; k < N; k++) check("final_mem", 64'(mem[k]), 64'(vecs[v].sorted[k]));
        end

        load_mem(mk(16'd9, 16'd8, 16'd7, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0).data);
        begin_sort();
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        check("abort_outputs", outs(), 64'(0));
        check("partial_mem0", 64'(mem[0]), 64'(16'd6));
        check("partial_mem2", 64'(mem[2]), 64'(16'd7));
        wr_q.delete();
        done_q.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_after_abort", 64'(bus.busy), 64'(0));
        end
        begin_sort();
        for (int c = 1; c <= DONE_AT + 2; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
            check("busy_resort", 64'(bus.busy), 64'(c <= DONE_AT));
        end
        check("resort_done_count", 64'(done_cnt), 64'(1));
        for (int k = 0; k < N; k++) check("resort_mem", 64'(mem[k]), 64'(16'd6 + 16'(k)));

        load_mem(mk(16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0).data);
        begin_sort();
        for (int c = 1; c <= 2 * DONE_AT + 3; c++) begin
            tick();
            if (c == 5) bus.start = 1'b0;
            if (c == 10) bus.start = 1'b1;
            if (c == DONE_AT) expect_sort(snap(), 2 * DONE_AT + 1);
            if (c == DONE_AT + 2) bus.start = 1'b0;
            check("busy_held", 64'(bus.busy),
                  64'((c <= DONE_AT) || (c >= DONE_AT + 2 && c <= 2 * DONE_AT + 1)));
        end
        check("held_done_count", 64'(done_cnt), 64'(2));
        check("held_queues_drained", 64'(wr_q.size() + done_q.size()), 64'(0));
        for (int k = 0; k < N; k++) check("held_mem", 64'(mem[k]), 64'(16'd1 + 16'(k)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
